pe_window_feeder: RTL and testbench
===================================

Name: pe_window_feeder

Overview:
- Producer side of the PE operand interface.
- Accepts a raster pixel stream of 2-channel 8-bit pixels and a serial 18-byte kernel.
- Assembles 3x3x2 windows into the 144-bit pe_image / pe_kernal vectors that drive the pe compute block.
- Uses valid (no-padding) convolution: (IMG_H-2)*(IMG_W-2) windows per frame, with a valid/ready handshake toward the PE-side consumer.

Parameters:
- IMG_W, 8, pixels per row (>=3).
- IMG_H, 8, rows per frame (>=3).
- BIT_W, 8, bits per channel sample.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pix_valid  in  1  pixel on i_pix_data valid.
- i_pix_data  in  16  [15:8]=channel 0, [7:0]=channel 1, signed Q-format bytes.
- o_pix_ready  out  1  pixel accepted when i_pix_valid && o_pix_ready.
- i_kern_valid  in  1  kernel byte valid.
- i_kern_data  in  8  kernel byte.
- o_kern_ready  out  1  kernel byte accepted when i_kern_valid && o_kern_ready.
- i_kern_reload  in  1  request new kernel load (honoured only at frame boundary).
- pe_image  out  144  window operand.
- pe_kernal  out  144  kernel operand.
- o_win_valid  out  1  pe_image holds a valid window.
- i_win_ready  in  1  consumer takes window when o_win_valid && i_win_ready.
- o_frame_done  out  1  one-cycle pulse after the last window of a frame is taken.

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - State S_KLOAD; all counters 0.
  - pe_image=0, pe_kernal=0, o_win_valid=0, o_frame_done=0, o_pix_ready=0.
  - o_kern_ready=1 from the first cycle after reset.
  - Line buffer contents are don't-care; they are never output before being overwritten.
- Packing (both vectors): byte index idx = c*9 + r*3 + k, placed at bits [143-8*idx -: 8].
  - c = channel, r = row (0 = top/oldest), k = column (0 = left/oldest).
  - Index 0 sits in the MSB byte.
- States:
  - S_KLOAD: o_kern_ready=1, o_pix_ready=0. Each accepted byte n (0..17) is written to kernel byte idx n. After byte 17 -> S_STREAM. pe_kernal updates byte-by-byte and is stable outside S_KLOAD.
  - S_STREAM:
    - o_pix_ready = !(o_win_valid && !i_win_ready); o_kern_ready=0.
    - On accept at (row,col), column taps are top=lb1[col], mid=lb0[col], bot=pixel.
    - lb1[col]<=lb0[col], lb0[col]<=pixel; the 3-column window shifts left and the taps enter column 2.
    - If row>=2 && col>=2: pe_image loads the window for rows row-2..row, cols col-2..col, and o_win_valid=1 in the next cycle (latency 1).
    - col wraps IMG_W-1 -> 0 and row increments. Accepting (IMG_H-1, IMG_W-1) -> S_DRAIN.
    - i_kern_reload with row==0 && col==0 && !o_win_valid -> S_KLOAD; otherwise ignored (not latched).
  - S_DRAIN: o_pix_ready=0. When the final window handshakes -> S_DONE.
  - S_DONE: o_frame_done=1 for exactly one cycle; counters cleared -> S_STREAM with the kernel retained.
- Window handshake:
  - o_win_valid clears on handshake unless a new window is loaded in the same cycle.
  - A pixel may be accepted in the same cycle as a handshake.
  - pe_image is held stable while o_win_valid && !i_win_ready.
- Kernel bytes offered outside S_KLOAD are not accepted. Pixels offered in S_KLOAD, S_DRAIN or S_DONE are not accepted.
- Windows never straddle rows: no output when col<2, and stale left columns are discarded.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H). No arithmetic is applied to data; bytes pass through bit-exact.

Decomposition:
- Shared package pe_pkg: BIT_W, PE_IMAGE_W=144, PE_KERNAL_W=144, window byte-index function, state enum.
- Sub-module pe_line_buffer: 2 x IMG_W x 16-bit row storage with a single read/shift port per accept.

Test Plan:
- Kernel load: bytes 0x01..0x12 -> pe_kernal[143:136]=0x01, [7:0]=0x12, o_kern_ready drops the cycle after the 18th byte.
- Single frame, IMG_W=IMG_H=4, ch0=r*16+c, ch1=0x80+r*16+c, i_win_ready=1:
  - exactly 4 windows;
  - first window pe_image[143:136]=0x00, [79:72]=0x22, [71:64]=0x80;
  - o_win_valid rises 1 cycle after accepting pixel (2,2).
- Backpressure: hold i_win_ready=0 for 5 cycles on the first window -> pe_image stable, o_pix_ready=0, no pixel lost; the remaining windows are correct.
- Frame end: o_frame_done pulses once, 1 cycle after the last window handshake; the second frame with the same kernel is produced correctly.
- Reload: i_kern_reload at frame boundary -> S_KLOAD and the new kernel is used. The same request mid-frame is ignored.
- Reset mid-frame: assert i_rst_n=0 after 6 pixels -> outputs 0, o_kern_ready=1; a kernel reload followed by a full frame is correct.

Source files
------------

// File: rtl/pe_window_feeder_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg : shared widths, window byte-index mapping and feeder state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pe_pkg;

  localparam int BIT_W       = 8;
  localparam int WIN_BYTES   = 18;
  localparam int PE_IMAGE_W  = WIN_BYTES * BIT_W;
  localparam int PE_KERNAL_W = WIN_BYTES * BIT_W;

  typedef enum logic [1:0] {
    S_KLOAD  = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } pe_state_e;

  // Byte 0 of the operand vectors is the MSB byte.
  function automatic int win_idx(input int c, input int r, input int k);
    return c * 9 + r * 3 + k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_window_feeder_line_buffer.sv
// ---------------------------------------------------------------------------
// pe_line_buffer : two-row pixel store, read and shifted at one column per accept
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pe_line_buffer #(
  parameter int IMG_W = 8,
  parameter int PIX_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_shift,
  input  logic [$clog2(IMG_W)-1:0] i_col,
  input  logic [PIX_W-1:0]         i_pix,
  output logic [PIX_W-1:0]         o_top,
  output logic [PIX_W-1:0]         o_mid
);

  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];

  assign o_top = lb1_q[i_col];
  assign o_mid = lb0_q[i_col];

  // Contents are never observed before being written, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (i_shift) begin
      lb1_q[i_col] <= lb0_q[i_col];
      lb0_q[i_col] <= i_pix;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_window_feeder.sv
// ---------------------------------------------------------------------------
// pe_window_feeder : builds 3x3x2 windows and kernel operand for the PE block
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pe_window_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int BIT_W = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_pix_valid,
  input  logic [2*BIT_W-1:0]                   i_pix_data,
  output logic                                 o_pix_ready,
  input  logic                                 i_kern_valid,
  input  logic [BIT_W-1:0]                     i_kern_data,
  output logic                                 o_kern_ready,
  input  logic                                 i_kern_reload,
  output logic [pe_pkg::WIN_BYTES*BIT_W-1:0]   pe_image,
  output logic [pe_pkg::WIN_BYTES*BIT_W-1:0]   pe_kernal,
  output logic                                 o_win_valid,
  input  logic                                 i_win_ready,
  output logic                                 o_frame_done
);
  import pe_pkg::*;

  localparam int PIX_W = 2 * BIT_W;
  localparam int VEC_W = WIN_BYTES * BIT_W;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO   = CW'(2);
  localparam logic [RW-1:0] ROW_TWO   = RW'(2);
  localparam logic [4:0]    KERN_LAST = 5'(WIN_BYTES - 1);

  pe_state_e                state_q;
  logic [RW-1:0]            row_q;
  logic [CW-1:0]            col_q;
  logic [4:0]               kcnt_q;
  logic [2:0][PIX_W-1:0]    wcola_q, wcolb_q;

  logic                     w_pix_acc, w_kern_acc, w_win_hs, w_reload, w_load;
  logic [PIX_W-1:0]         w_top, w_mid;
  logic [2:0][PIX_W-1:0]    w_newcol;
  logic [2:0][2:0][PIX_W-1:0] w_cols;
  logic [VEC_W-1:0]         w_img_d;

  assign w_win_hs    = o_win_valid && i_win_ready;
  assign w_reload    = (state_q == S_STREAM) && i_kern_reload &&
                       (row_q == '0) && (col_q == '0) && !o_win_valid;
  // A taken reload must not also swallow a pixel in the same cycle.
  assign o_pix_ready = (state_q == S_STREAM) && !(o_win_valid && !i_win_ready) && !w_reload;
  assign o_kern_ready = (state_q == S_KLOAD);
  assign w_pix_acc   = i_pix_valid && o_pix_ready;
  assign w_kern_acc  = i_kern_valid && o_kern_ready;
  assign w_load      = w_pix_acc && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  pe_line_buffer #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W)
  ) u_line_buffer (
    .i_clk   (i_clk),
    .i_shift (w_pix_acc),
    .i_col   (col_q),
    .i_pix   (i_pix_data),
    .o_top   (w_top),
    .o_mid   (w_mid)
  );

  assign w_newcol = {i_pix_data, w_mid, w_top};
  assign w_cols   = {w_newcol, wcolb_q, wcola_q};

  always_comb begin
    w_img_d = '0;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          w_img_d[VEC_W-1-BIT_W*win_idx(c, r, k) -: BIT_W] = w_cols[k][r][PIX_W-1-BIT_W*c -: BIT_W];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_KLOAD;
      row_q        <= '0;
      col_q        <= '0;
      kcnt_q       <= '0;
      wcola_q      <= '0;
      wcolb_q      <= '0;
      pe_image     <= '0;
      pe_kernal    <= '0;
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (w_win_hs) o_win_valid <= 1'b0;
      case (state_q)
        S_KLOAD: begin
          if (w_kern_acc) begin
            pe_kernal[VEC_W-1-BIT_W*int'(kcnt_q) -: BIT_W] <= i_kern_data;
            if (kcnt_q == KERN_LAST) begin
              kcnt_q  <= '0;
              state_q <= S_STREAM;
            end else begin
              kcnt_q <= kcnt_q + 5'd1;
            end
          end
        end
        S_STREAM: begin
          if (w_reload) begin
            state_q <= S_KLOAD;
          end else if (w_pix_acc) begin
            wcola_q <= wcolb_q;
            wcolb_q <= w_newcol;
            if (w_load) begin
              pe_image    <= w_img_d;
              o_win_valid <= 1'b1;
            end
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                row_q   <= '0;
                state_q <= S_DRAIN;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_win_hs) begin
            state_q      <= S_DONE;
            o_frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          row_q   <= '0;
          col_q   <= '0;
          state_q <= S_STREAM;
        end
        default: state_q <= S_KLOAD;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_pe_window_feeder : directed self-checking bench for a 4x4 frame feeder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pe_window_feeder;

  logic         clk;
  logic         i_rst_n;
  logic         i_pix_valid;
  logic [15:0]  i_pix_data;
  logic         o_pix_ready;
  logic         i_kern_valid;
  logic [7:0]   i_kern_data;
  logic         o_kern_ready;
  logic         i_kern_reload;
  logic [143:0] pe_image;
  logic [143:0] pe_kernal;
  logic         o_win_valid;
  logic         i_win_ready;
  logic         o_frame_done;

  int n_checks = 0;
  int n_err    = 0;

  pe_window_feeder #(
    .IMG_W (4),
    .IMG_H (4),
    .BIT_W (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_pix_valid   (i_pix_valid),
    .i_pix_data    (i_pix_data),
    .o_pix_ready   (o_pix_ready),
    .i_kern_valid  (i_kern_valid),
    .i_kern_data   (i_kern_data),
    .o_kern_ready  (o_kern_ready),
    .i_kern_reload (i_kern_reload),
    .pe_image      (pe_image),
    .pe_kernal     (pe_kernal),
    .o_win_valid   (o_win_valid),
    .i_win_ready   (i_win_ready),
    .o_frame_done  (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int p);
    int r, c;
    r = p / 4;
    c = p % 4;
    return {8'(r * 16 + c), 8'(128 + r * 16 + c)};
  endfunction

  // Window whose bottom-right pixel is (rr, cc).
  function automatic logic [143:0] exp_win(input int rr, input int cc);
    logic [143:0] v;
    int idx, pr, pc;
    v = '0;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++) begin
          idx = c * 9 + r * 3 + k;
          pr  = rr - 2 + r;
          pc  = cc - 2 + k;
          v[143 - 8 * idx -: 8] = (c == 0) ? 8'(pr * 16 + pc) : 8'(128 + pr * 16 + pc);
        end
    return v;
  endfunction

  function automatic logic [143:0] exp_kern(input int base);
    logic [143:0] v;
    v = '0;
    for (int n = 0; n < 18; n++) v[143 - 8 * n -: 8] = 8'(base + n);
    return v;
  endfunction

  task automatic load_kernel(input int base);
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      i_kern_valid = 1'b1;
      i_kern_data  = 8'(base + n);
      #1;
      chk("kern_ready_during_load", o_kern_ready, 1);
    end
    @(negedge clk);
    i_kern_valid = 1'b0;
    #1;
    chk("kern_ready_drop", o_kern_ready, 0);
    chk("kernel_vector", pe_kernal, exp_kern(base));
  endtask

  task automatic run_frame(input string tag, input bit stall, input bit mid_reload, input int kbase);
    int pidx, widx, nstall, acc10, firstv, last_hs, fd_cyc, fd_cnt;
    pidx = 0; widx = 0; nstall = 0; acc10 = -1; firstv = -1;
    last_hs = -1; fd_cyc = -1; fd_cnt = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      i_pix_valid   = (pidx < 16);
      i_pix_data    = pix(pidx);
      i_win_ready   = !(stall && nstall < 5);
      i_kern_reload = mid_reload && pidx > 0 && pidx < 16;
      i_kern_valid  = 1'b1;
      i_kern_data   = 8'hEE;
      #1;
      if (firstv < 0 && o_win_valid) firstv = cyc;
      if (o_win_valid && !i_win_ready) begin
        chk({tag, "_held_image"}, pe_image, exp_win(2, 2));
        chk({tag, "_bp_pix_ready"}, o_pix_ready, 0);
        nstall++;
      end
      if (o_win_valid && i_win_ready) begin
        chk({tag, "_window"}, pe_image, exp_win(2 + widx / 2, 2 + widx % 2));
        chk({tag, "_kernel"}, pe_kernal, exp_kern(kbase));
        widx++;
        last_hs = cyc;
      end
      if (o_frame_done) begin
        fd_cnt++;
        if (fd_cyc < 0) fd_cyc = cyc;
      end
      if (i_pix_valid && o_pix_ready) begin
        if (pidx == 10) acc10 = cyc;
        pidx++;
      end
      if (fd_cyc >= 0 && cyc >= fd_cyc + 3) break;
    end
    i_pix_valid   = 1'b0;
    i_kern_reload = 1'b0;
    i_kern_valid  = 1'b0;
    i_win_ready   = 1'b1;
    chk({tag, "_pixels_taken"}, pidx, 16);
    chk({tag, "_window_count"}, widx, 4);
    chk({tag, "_first_valid_latency"}, firstv, acc10 + 1);
    chk({tag, "_frame_done_count"}, fd_cnt, 1);
    chk({tag, "_frame_done_timing"}, fd_cyc, last_hs + 1);
    chk({tag, "_kern_ready_after"}, o_kern_ready, 0);
    if (stall) chk({tag, "_stall_cycles"}, nstall, 5);
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_pix_valid   = 1'b0;
    i_pix_data    = '0;
    i_kern_valid  = 1'b0;
    i_kern_data   = '0;
    i_kern_reload = 1'b0;
    i_win_ready   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pe_image", pe_image, 0);
    chk("rst_pe_kernal", pe_kernal, 0);
    chk("rst_win_valid", o_win_valid, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_pix_ready", o_pix_ready, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    chk("post_rst_kern_ready", o_kern_ready, 1);
    chk("post_rst_pix_ready", o_pix_ready, 0);

    load_kernel(8'h01);
    chk("kernel_msb_byte", pe_kernal[143:136], 8'h01);
    chk("kernel_lsb_byte", pe_kernal[7:0], 8'h12);

    run_frame("f1", 1'b0, 1'b0, 8'h01);
    run_frame("f2_backpressure", 1'b1, 1'b0, 8'h01);
    run_frame("f3_midframe_reload", 1'b0, 1'b1, 8'h01);

    @(negedge clk);
    i_kern_reload = 1'b1;
    #1;
    chk("reload_pix_ready", o_pix_ready, 0);
    @(negedge clk);
    i_kern_reload = 1'b0;
    #1;
    chk("reload_kern_ready", o_kern_ready, 1);
    load_kernel(8'h41);
    run_frame("f4_new_kernel", 1'b0, 1'b0, 8'h41);

    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      i_pix_valid = 1'b1;
      i_pix_data  = pix(p);
    end
    @(negedge clk);
    i_pix_valid = 1'b0;
    i_rst_n     = 1'b0;
    #1;
    chk("midrst_pe_image", pe_image, 0);
    chk("midrst_pe_kernal", pe_kernal, 0);
    chk("midrst_win_valid", o_win_valid, 0);
    chk("midrst_frame_done", o_frame_done, 0);
    chk("midrst_pix_ready", o_pix_ready, 0);
    chk("midrst_kern_ready", o_kern_ready, 1);
    @(negedge clk);
    i_rst_n = 1'b1;
    load_kernel(8'h61);
    run_frame("f5_after_reset", 1'b0, 1'b0, 8'h61);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
